// File: rtl/clb_config_sequencer.sv
// Configuration and run sequencer for the 4x4 CLB cell array.
// Configuration words stream into a shadow register. On an accepted start
// the shadow is committed atomically to cfg_active. The sequencer then
// pulses op_latch, waits SETTLE_CYCLES for the array to resolve, pulses
// capture and finally pulses done.
// Active configuration layout (shadow is identical):
//   cell c = 4*row+col : bits [8c+7:8c] = {selOp[1:0], sel1[2:0], sel0[2:0]}
//   column j bypass    : bits [128+4j+3:128+4j]
//   config word k      : bits [16k+15:16k]
module clb_config_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,   // legal range 1..255
    parameter int unsigned NUM_WORDS     = 9    // fixed by the 144-bit layout
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               cfg_data,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      start,
    output logic [NUM_WORDS*16-1:0]   cfg_active,
    output logic                      op_latch,
    output logic                      capture,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_complete,
    output logic                      start_err,
    output logic [15:0]               run_count
);

    localparam int unsigned CFG_BITS    = NUM_WORDS * 16;
    localparam logic [3:0]  LAST_WORD   = 4'(NUM_WORDS - 1);
    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPT,
        ST_DONE
    } state_e;

    state_e                state_q,        state_d;
    logic [3:0]            word_cnt_q,     word_cnt_d;
    logic [7:0]            settle_cnt_q,   settle_cnt_d;
    logic                  cfg_complete_q, cfg_complete_d;
    logic                  op_latch_q,     op_latch_d;
    logic                  start_err_q,    start_err_d;
    logic [15:0]           run_count_q,    run_count_d;
    logic [CFG_BITS-1:0]   cfg_active_q,   cfg_active_d;
    logic [CFG_BITS-1:0]   shadow_q;

    logic                  word_accept;

    // The sequencer never back-pressures the configuration stream.
    assign cfg_ready   = 1'b1;
    assign word_accept = cfg_valid & cfg_ready;

    // Next-state, counter and commit logic.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        cfg_complete_d = cfg_complete_q;
        op_latch_d     = 1'b0;
        start_err_d    = 1'b0;
        run_count_d    = run_count_q;
        cfg_active_d   = cfg_active_q;

        unique case (state_q)
            ST_IDLE: begin
                // The commit uses the shadow and completion flag as they
                // were before any word written in this same cycle.
                if (start) begin
                    if (cfg_complete_q) begin
                        cfg_active_d   = shadow_q;
                        cfg_complete_d = 1'b0;
                        settle_cnt_d   = SETTLE_LOAD;
                        op_latch_d     = 1'b1;
                        state_d        = ST_SETTLE;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 8'd0) begin
                    state_d = ST_CAPT;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            ST_CAPT: begin
                run_count_d = run_count_q + 16'd1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                // A start here is dropped silently; the next one is taken
                // in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Word loading runs independently of the run FSM. Its effect on
        // cfg_complete takes priority over the commit clearing it.
        if (word_accept) begin
            if (word_cnt_q == LAST_WORD) begin
                word_cnt_d     = 4'd0;
                cfg_complete_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + 4'd1;
                if (word_cnt_q == 4'd0) begin
                    cfg_complete_d = 1'b0;
                end
            end
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q        <= ST_IDLE;
            word_cnt_q     <= 4'd0;
            settle_cnt_q   <= 8'd0;
            cfg_complete_q <= 1'b0;
            op_latch_q     <= 1'b0;
            start_err_q    <= 1'b0;
            run_count_q    <= 16'd0;
            cfg_active_q   <= '0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            cfg_complete_q <= cfg_complete_d;
            op_latch_q     <= op_latch_d;
            start_err_q    <= start_err_d;
            run_count_q    <= run_count_d;
            cfg_active_q   <= cfg_active_d;
        end
    end

    // Shadow register: one 16-bit slot written per accepted word.
    always_ff @(posedge clk) begin
        // NOTE: the shadow has no reset; its contents are meaningless until
        // cfg_complete is set, so clearing 144 flops would buy nothing.
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            if (word_accept && (word_cnt_q == 4'(k))) begin
                shadow_q[16*k +: 16] <= cfg_data;
            end
        end
    end

    assign cfg_active   = cfg_active_q;
    assign op_latch     = op_latch_q;
    assign start_err    = start_err_q;
    assign cfg_complete = cfg_complete_q;
    assign run_count    = run_count_q;
    assign capture      = (state_q == ST_CAPT);
    assign busy         = (state_q == ST_SETTLE) || (state_q == ST_CAPT);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_clb_config_sequencer.sv
// Directed bench for clb_config_sequencer with SETTLE_CYCLES = 4.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the
// same point, so each check sees the state produced by the preceding edge.
module tb_clb_config_sequencer;

    logic           clk;
    logic           rst;
    logic [15:0]    cfg_data;
    logic           cfg_valid;
    logic           cfg_ready;
    logic           start;
    logic [143:0]   cfg_active;
    logic           op_latch;
    logic           capture;
    logic           busy;
    logic           done;
    logic           cfg_complete;
    logic           start_err;
    logic [15:0]    run_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Hand-written configuration sets, word 8 leftmost.
    localparam logic [143:0] SET_A = 144'h0808_0707_0606_0505_0404_0303_0202_0101_0000;
    localparam logic [143:0] SET_B = 144'h9999_8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [143:0] SET_C = 144'hA008_A007_A006_A005_A004_A003_A002_A001_A000;
    localparam logic [143:0] SET_D = 144'hD008_D007_D006_D005_D004_D003_D002_D001_D000;
    localparam logic [143:0] SET_E = 144'hE008_E007_E006_E005_E004_E003_E002_E001_EEEE;
    localparam logic [143:0] SET_F = 144'h3008_3007_3006_3005_3004_3003_3002_3001_3000;

    clb_config_sequencer #(
        .SETTLE_CYCLES (4),
        .NUM_WORDS     (9)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .start        (start),
        .cfg_active   (cfg_active),
        .op_latch     (op_latch),
        .capture      (capture),
        .busy         (busy),
        .done         (done),
        .cfg_complete (cfg_complete),
        .start_err    (start_err),
        .run_count    (run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check144(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        cfg_data  = w;
        cfg_valid = 1'b1;
        tick();
    endtask

    initial begin
        logic seen_pulse;

        rst       = 1'b1;
        cfg_data  = 16'h0000;
        cfg_valid = 1'b0;
        start     = 1'b0;
        tick();
        tick();

        // Reset state
        check144("rst_active", cfg_active, 144'h0);
        check1("rst_ready", cfg_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_complete", cfg_complete, 1'b0);
        check1("rst_op_latch", op_latch, 1'b0);
        check1("rst_capture", capture, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_start_err", start_err, 1'b0);
        check16("rst_run_count", run_count, 16'h0);
        rst = 1'b0;
        tick();

        // Load set A (16'h0101*k) back to back
        for (int k = 0; k < 8; k++) push(16'(16'h0101 * k));
        check1("a_not_complete_before_w8", cfg_complete, 1'b0);
        push(16'h0808);
        cfg_valid = 1'b0;
        check1("a_complete", cfg_complete, 1'b1);
        check144("a_active_still_zero", cfg_active, 144'h0);

        // Run: op_latch at t+1, capture at t+5, done at t+6
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("a_op_latch", op_latch, 1'b1);
        check1("a_busy", busy, 1'b1);
        check144("a_active", cfg_active, SET_A);
        check16("a_active_lo", cfg_active[15:0], 16'h0000);
        check16("a_active_hi", cfg_active[143:128], 16'h0808);
        check1("a_complete_cleared", cfg_complete, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("a_no_early_capture", capture, 1'b0);
            check1("a_op_latch_once", op_latch, 1'b0);
        end
        tick();
        check1("a_capture", capture, 1'b1);
        check1("a_busy_at_capture", busy, 1'b1);
        check1("a_no_done_at_capture", done, 1'b0);
        tick();
        check1("a_done", done, 1'b1);
        check1("a_busy_low_in_done", busy, 1'b0);
        check1("a_capture_once", capture, 1'b0);
        check16("a_run_count", run_count, 16'd1);
        tick();
        check1("a_done_once", done, 1'b0);

        // Start without a complete configuration
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("err_pulse", start_err, 1'b1);
        check1("err_busy", busy, 1'b0);
        check144("err_active_kept", cfg_active, SET_A);
        tick();
        check1("err_pulse_once", start_err, 1'b0);
        check1("err_still_idle", busy, 1'b0);

        // Load set B and run it; load set C during the run with stray starts
        for (int k = 0; k < 9; k++) push(16'(16'h1111 * (k + 1)));
        cfg_valid = 1'b0;
        check1("b_complete", cfg_complete, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("b_op_latch", op_latch, 1'b1);
        check144("b_active", cfg_active, SET_B);
        for (int k = 0; k < 9; k++) begin
            cfg_data  = 16'(16'hA000 + k);
            cfg_valid = 1'b1;
            // k=1 lands in SETTLE, k=4 in CAPT, k=5 in DONE
            start     = (k == 1) || (k == 4) || (k == 5);
            tick();
            check1("c_no_start_err", start_err, 1'b0);
            check144("c_active_held", cfg_active, SET_B);
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
        check1("c_complete", cfg_complete, 1'b1);
        check16("b_run_count", run_count, 16'd2);
        check1("c_idle", busy, 1'b0);

        // Start after done commits set C
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("c_op_latch", op_latch, 1'b1);
        check144("c_active", cfg_active, SET_C);
        check1("c_complete_cleared", cfg_complete, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check1("c_capture", capture, 1'b1);
        tick();
        check1("c_done", done, 1'b1);
        check16("c_run_count", run_count, 16'd3);
        tick();

        // Start together with a new word 0 while set D is complete
        for (int k = 0; k < 9; k++) push(16'(16'hD000 + k));
        check1("d_complete", cfg_complete, 1'b1);
        cfg_data  = 16'hEEEE;
        cfg_valid = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check1("d_op_latch", op_latch, 1'b1);
        check144("d_active_old_shadow", cfg_active, SET_D);
        check1("d_complete_cleared", cfg_complete, 1'b0);
        for (int k = 1; k < 9; k++) push(16'(16'hE000 + k));
        cfg_valid = 1'b0;
        check1("e_complete", cfg_complete, 1'b1);
        check16("d_run_count", run_count, 16'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check144("e_active_has_word0", cfg_active, SET_E);
        for (int i = 0; i < 5; i++) tick();
        check1("e_done", done, 1'b1);
        check16("e_run_count", run_count, 16'd5);
        tick();

        // Start together with word 8 while incomplete
        for (int k = 0; k < 8; k++) push(16'(16'h3000 + k));
        cfg_data  = 16'h3008;
        cfg_valid = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cfg_valid = 1'b0;
        check1("f_start_err", start_err, 1'b1);
        check1("f_complete_set", cfg_complete, 1'b1);
        check1("f_no_run", busy, 1'b0);
        check1("f_no_op_latch", op_latch, 1'b0);
        check144("f_active_kept", cfg_active, SET_E);
        tick();
        check1("f_err_once", start_err, 1'b0);

        // Reset two cycles into SETTLE
        start = 1'b1;
        tick();
        start = 1'b0;
        check144("f_active", cfg_active, SET_F);
        tick();
        check1("f_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        #1;
        check1("mid_rst_busy", busy, 1'b0);
        check144("mid_rst_active", cfg_active, 144'h0);
        check16("mid_rst_run_count", run_count, 16'd0);
        check1("mid_rst_complete", cfg_complete, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        seen_pulse = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_pulse = seen_pulse | capture | done | op_latch;
        end
        check1("post_rst_no_pulses", seen_pulse, 1'b0);
        check16("post_rst_run_count", run_count, 16'd0);
        check1("post_rst_idle", busy, 1'b0);

        // Partial load was discarded: start is rejected
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("post_rst_start_err", start_err, 1'b1);
        check144("post_rst_active", cfg_active, 144'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clb_config_sequencer.md
Name: clb_config_sequencer

Overview:
Control block for the 4x4 CLB cell array. It collects the array's 144-bit configuration as 16-bit words into a shadow register, then commits it atomically to an active register that drives every operand select, operation select and column bypass. On each run it latches operands, waits a programmable settle time for the combinational array to resolve, and then pulses a capture strobe. The shadow register allows the next configuration to load while the current run is in progress.

Parameters:
SETTLE_CYCLES, 4, cycles between operand latch and capture strobe; legal range 1..255.
NUM_WORDS, 9, 16-bit configuration words per full configuration; fixed by the 144-bit layout.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
cfg_data  input  16  configuration word.
cfg_valid  input  1  cfg_data is valid this cycle.
cfg_ready  output  1  sequencer accepts a word; a transfer occurs on cfg_valid & cfg_ready.
start  input  1  request a run; sampled every cycle.
cfg_active  output  144  active configuration driving the array.
op_latch  output  1  one-cycle pulse: the array input registers load operands.
capture  output  1  one-cycle pulse: the array output registers sample results.
busy  output  1  high from start acceptance until the cycle after capture.
done  output  1  one-cycle pulse, the cycle after capture.
cfg_complete  output  1  the shadow register holds a full, uncommitted configuration.
start_err  output  1  one-cycle pulse: start was rejected because cfg_complete was 0.
run_count  output  16  number of completed runs; wraps at 16'hFFFF to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - cfg_active = 0, which gives all cells sel 0, selOp 0 and no bypass.
  - State = IDLE.
  - Word counter = 0.
  - cfg_complete, op_latch, capture, busy, done, start_err = 0.
  - run_count = 0.
  - cfg_ready = 1.
  - The shadow register contents are don't-care.
- Configuration layout (cfg_active and shadow):
  - Cell c = 4*row + col occupies bits [8c+7:8c]: [2:0] sel0, [5:3] sel1, [7:6] selOp.
  - Column j bypass occupies bits [128+4j+3:128+4j].
  - Word k fills bits [16k+15:16k], for k = 0..8.
- Loading:
  - cfg_ready = 1 in every state after reset.
  - Each accepted word is written to shadow slot k, and k increments.
  - Accepting word 0 clears cfg_complete.
  - Accepting word 8 sets cfg_complete and wraps k to 0.
  - No other event changes k.
- FSM states: IDLE, SETTLE, CAPT, DONE.
  - IDLE:
    - start with cfg_complete = 1: copy shadow to cfg_active, clear cfg_complete, load the settle counter with SETTLE_CYCLES-1, go to SETTLE. op_latch and busy are high in the next cycle, aligned with the new cfg_active.
    - start with cfg_complete = 0: pulse start_err for one cycle and stay in IDLE.
  - SETTLE: decrement the counter. When the counter is 0, go to CAPT. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - CAPT: capture = 1 for one cycle; increment run_count; go to DONE.
  - DONE: done = 1 and busy = 0; return to IDLE. A start in DONE is ignored without raising start_err.
- Latency: with start sampled at cycle t, op_latch is at t+1, capture at t+1+SETTLE_CYCLES, and done at t+2+SETTLE_CYCLES.
- start in SETTLE or CAPT: ignored; no error.
- Simultaneous start and word accept in IDLE:
  - The commit uses the pre-write shadow and the pre-write cfg_complete.
  - The accepted word is still written to the shadow.
  - If that word is word 0, cfg_complete ends at 0.
  - If that word is word 8 and cfg_complete was 0, start_err pulses, and cfg_complete ends at 1.
- cfg_active changes only on a commit or on reset; it is stable throughout SETTLE and CAPT.
- Reset mid-run: all outputs take reset values immediately, any partial load is discarded, and no capture or done pulse is issued.

Test Plan:
- Reset, then load 9 words 16'h0101*k with cfg_valid held high -> cfg_complete rises the cycle after word 8; cfg_active is still 0.
- Pulse start at cycle t with SETTLE_CYCLES = 4 -> op_latch at t+1, capture at t+5, done at t+6; cfg_active[15:0] = 16'h0000 and [143:128] = 16'h0808; run_count = 1; cfg_complete = 0.
- Pulse start with no complete configuration -> start_err pulses once, busy stays 0, cfg_active is unchanged.
- During SETTLE, load a full new set of 9 words and pulse start -> the start is ignored and cfg_active is unchanged until the run completes; a start after done commits the new set.
- Hold cfg_complete = 1, then assert start together with a new word 0 in the same cycle -> the old shadow is committed, the new word 0 lands in the shadow, and cfg_complete = 0.
- Assert rst two cycles into SETTLE -> busy = 0 and cfg_active = 0 immediately; no capture or done pulse; run_count = 0.
